// File: rtl/rv32i_ctrl_pkg.sv
// rtl/rv32i_ctrl_pkg.sv - shared constants and helpers for the RV32I multi-cycle controller
// Purpose: opcode constants, 3-bit state encoding, ALU op encodings, mux select
//          constants and small opcode decode helpers shared by the controller files.
// Ports:   none (package).
package rv32i_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b01;
  localparam logic [1:0] ALU_OP_BR    = 2'b10;

  localparam logic PC_SEL_PLUS4 = 1'b0;
  localparam logic PC_SEL_IMM   = 1'b1;
  localparam logic WB_SEL_ALU   = 1'b0;
  localparam logic WB_SEL_MEM   = 1'b1;

  typedef struct packed {
    logic       b_sel;
    logic [1:0] op;
  } alu_ctrl_t;

  function automatic logic opc_is_legal(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_OP: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  // ALU operand/op selection for an opcode; held constant from EXEC through WB.
  function automatic alu_ctrl_t alu_ctrl_for(input logic [6:0] opc);
    alu_ctrl_t c;
    c.b_sel = 1'b0;
    c.op    = ALU_OP_ADD;
    case (opc)
      OPC_LOAD, OPC_STORE: begin c.b_sel = 1'b1; c.op = ALU_OP_ADD;   end
      OPC_OPIMM:           begin c.b_sel = 1'b1; c.op = ALU_OP_FUNCT; end
      OPC_OP:              begin c.b_sel = 1'b0; c.op = ALU_OP_FUNCT; end
      OPC_BRANCH:          begin c.b_sel = 1'b0; c.op = ALU_OP_BR;    end
      default:             begin c.b_sel = 1'b0; c.op = ALU_OP_ADD;   end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait counter for memory request/ready handshakes
// Purpose: counts cycles a request waits for ready and flags the last allowed cycle.
// Ports:   clk, rst_n (async active-low); clr clears the count; en counts one
//          waiting cycle; expired is high while the count equals TIMEOUT-1.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// rtl/rv32i_multicycle_ctrl.sv - multi-cycle control FSM for the RV32I datapath
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes and
//          muxes, owns imem/dmem request handshakes, traps on illegal opcode
//          or memory timeout (sticky flags, cleared only by rst_n).
// Ports:   clk, rst_n; inst_in (IR contents), br_taken, imem_ready, dmem_ready;
//          imem_req, ir_we, pc_we, pc_sel, alu_b_sel, alu_op, dmem_req,
//          dmem_we, reg_we, wb_sel, illegal_inst, bus_err, state_o (debug).
module rv32i_multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_in,
  input  logic        br_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        illegal_inst,
  output logic        bus_err,
  output logic [2:0]  state_o
);

  state_e     state_q, state_d;
  logic [6:0] opc_q, opc_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       timer_clr, timer_en, timer_expired;
  alu_ctrl_t  alu_c;

  // Only the opcode field steers control; the rest of the word belongs to the datapath.
  logic       unused_inst;
  assign unused_inst = ^inst_in[31:7];

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    timer_en  = 1'b0;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PLUS4;
    alu_b_sel = 1'b0;
    alu_op    = ALU_OP_ADD;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_SEL_ALU;
    alu_c     = alu_ctrl_for(opc_q);

    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            state_d   = ST_TRAP;
            bus_err_d = 1'b1;
          end
        end
      end

      // The IR is valid from here on; latch the opcode so EXEC..WB never
      // look at inst_in again.
      ST_DECODE: begin
        opc_d = inst_in[6:0];
        if (opc_is_legal(inst_in[6:0])) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end
      end

      ST_EXEC: begin
        alu_b_sel = alu_c.b_sel;
        alu_op    = alu_c.op;
        case (opc_q)
          OPC_LOAD, OPC_STORE: state_d = ST_MEM;
          OPC_OPIMM, OPC_OP:   state_d = ST_WB;
          OPC_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
            state_d = ST_FETCH;
          end
          default:             state_d = ST_TRAP;
        endcase
      end

      ST_MEM: begin
        alu_b_sel = alu_c.b_sel;
        alu_op    = alu_c.op;
        dmem_req  = 1'b1;
        dmem_we   = (opc_q == OPC_STORE);
        if (dmem_ready) begin
          if (opc_q == OPC_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            state_d   = ST_TRAP;
            bus_err_d = 1'b1;
          end
        end
      end

      ST_WB: begin
        alu_b_sel = alu_c.b_sel;
        alu_op    = alu_c.op;
        reg_we    = 1'b1;
        wb_sel    = (opc_q == OPC_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
        pc_we     = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_IDLE;
    endcase

    // Restart the wait count each time a request phase begins.
    timer_clr = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opc_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign illegal_inst = illegal_q;
  assign bus_err      = bus_err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb/tb_rv32i_multicycle_ctrl.sv - self-checking bench for rv32i_multicycle_ctrl
module tb_rv32i_multicycle_ctrl;

  localparam int TO = 8;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

  localparam logic [6:0] L_LOAD = 7'b0000011, L_OPIMM = 7'b0010011, L_STORE = 7'b0100011,
                         L_BRANCH = 7'b1100011, L_OP = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_in;
  logic        br_taken, imem_ready, dmem_ready;
  logic        imem_req, ir_we, pc_we, pc_sel, alu_b_sel;
  logic [1:0]  alu_op;
  logic        dmem_req, dmem_we, reg_we, wb_sel, illegal_inst, bus_err;
  logic [2:0]  state_o;
  logic [15:0] obs;

  always #5 clk = ~clk;

  rv32i_multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_in      (inst_in),
    .br_taken     (br_taken),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op       (alu_op),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .illegal_inst (illegal_inst),
    .bus_err      (bus_err),
    .state_o      (state_o)
  );

  assign obs = {illegal_inst, bus_err, imem_req, ir_we, pc_we, pc_sel, alu_b_sel,
                alu_op, dmem_req, dmem_we, reg_we, wb_sel, state_o};

  typedef struct {
    logic [31:0] inst;
    logic        ir;
    logic        dr;
    logic        br;
    logic [15:0] exp;
  } row_t;

  row_t  trace[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  m_ill, m_be;
  string cur_tag;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expected output vector for one cycle; sticky flags come from the model state.
  function automatic logic [15:0] ex(input logic [2:0] st, input logic ireq, input logic irwe,
                                     input logic pcwe, input logic pcsel, input logic bsel,
                                     input logic [1:0] aop, input logic dreq, input logic dwe,
                                     input logic rwe, input logic wsel);
    return {m_ill, m_be, ireq, irwe, pcwe, pcsel, bsel, aop, dreq, dwe, rwe, wsel, st};
  endfunction

  function automatic void push(input logic [31:0] w, input logic ir, input logic dr,
                               input logic br, input logic [15:0] e);
    row_t r;
    r.inst = w; r.ir = ir; r.dr = dr; r.br = br; r.exp = e;
    trace.push_back(r);
  endfunction

  function automatic void model_idle();
    push($urandom, rb(), rb(), rb(), ex(S_IDLE, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
  endfunction

  function automatic void model_trap(input int n);
    for (int i = 0; i < n; i++)
      push($urandom, rb(), rb(), rb(), ex(S_TRAP, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
  endfunction

  // One instruction from its first FETCH cycle. fd/md = ready delay in cycles;
  // a delay of TO or more means ready never arrives in time.
  function automatic void model_instr(input logic [31:0] w, input int fd, input int md,
                                      input logic br);
    logic [6:0] opc;
    logic       bsel, ld, st;
    logic [1:0] aop;
    opc  = w[6:0];
    ld   = (opc == L_LOAD);
    st   = (opc == L_STORE);
    bsel = 1'b0;
    aop  = 2'b00;
    for (int i = 0; i < fd && i < TO; i++)
      push($urandom, 1'b0, rb(), rb(), ex(S_FETCH, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    if (fd >= TO) begin m_be = 1'b1; return; end
    push($urandom, 1'b1, rb(), rb(), ex(S_FETCH, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    push(w, rb(), rb(), rb(), ex(S_DECODE, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    if (ld || st)          begin bsel = 1'b1; aop = 2'b00; end
    else if (opc == L_OPIMM) begin bsel = 1'b1; aop = 2'b01; end
    else if (opc == L_OP)    begin bsel = 1'b0; aop = 2'b01; end
    else if (opc == L_BRANCH) begin
      push(w, rb(), rb(), br, ex(S_EXEC, 0, 0, 1, br, 0, 2'b10, 0, 0, 0, 0));
      return;
    end else begin
      m_ill = 1'b1;
      return;
    end
    push(w, rb(), rb(), rb(), ex(S_EXEC, 0, 0, 0, 0, bsel, aop, 0, 0, 0, 0));
    if (ld || st) begin
      for (int i = 0; i < md && i < TO; i++)
        push(w, rb(), 1'b0, rb(), ex(S_MEM, 0, 0, 0, 0, bsel, aop, 1, st, 0, 0));
      if (md >= TO) begin m_be = 1'b1; return; end
      push(w, rb(), 1'b1, rb(), ex(S_MEM, 0, 0, st, 0, bsel, aop, 1, st, 0, 0));
      if (st) return;
    end
    push(w, rb(), rb(), rb(), ex(S_WB, 0, 0, 1, 0, bsel, aop, 0, 0, 1, ld));
  endfunction

  task automatic run_trace(input int max_rows);
    row_t r;
    int   n;
    n = 0;
    while (trace.size() > 0 && n < max_rows) begin
      r = trace.pop_front();
      inst_in = r.inst; imem_ready = r.ir; dmem_ready = r.dr; br_taken = r.br;
      #1;
      n_tests++;
      assert (obs === r.exp) else begin
        n_fail++;
        $error("FAIL %s row %0d: observed %h expected %h", cur_tag, n, obs, r.exp);
      end
      @(negedge clk);
      n++;
    end
    trace.delete();
  endtask

  // Reset asserted mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_ill = 1'b0;
    m_be  = 1'b0;
    #1;
    n_tests++;
    assert (obs === 16'h0000) else begin
      n_fail++;
      $error("FAIL async_reset_%s: observed %h expected %h", cur_tag, obs, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [6:0] opcs [5];
    opcs[0] = L_LOAD; opcs[1] = L_OPIMM; opcs[2] = L_STORE; opcs[3] = L_BRANCH; opcs[4] = L_OP;
    return {25'($urandom), opcs[$urandom_range(0, 4)]};
  endfunction

  initial begin
    rst_n = 1'b0; inst_in = $urandom; imem_ready = 1'b1; dmem_ready = 1'b1; br_taken = 1'b1;
    m_ill = 1'b0; m_be = 1'b0;

    cur_tag = "por";
    do_reset();

    cur_tag = "directed";
    model_idle();
    model_instr(32'h00500093, 0, 0, 1'b0);
    model_instr(32'h0040A103, 1, 3, 1'b0);
    model_instr(32'h0020A423, 0, 2, 1'b0);
    model_instr(32'h00000463, 0, 0, 1'b1);
    model_instr(32'h00000463, 2, 0, 1'b0);
    run_trace(1000);

    cur_tag = "random";
    for (int k = 0; k < 40; k++)
      model_instr(rand_legal(), $urandom_range(0, 4), $urandom_range(0, 4), rb());
    run_trace(5000);

    cur_tag = "illegal";
    model_instr(32'h0000007F, 1, 0, 1'b0);
    model_trap(20);
    run_trace(1000);
    do_reset();
    model_idle();
    model_instr(32'h00500093, 0, 0, 1'b0);
    run_trace(1000);

    cur_tag = "fetch_timeout";
    model_instr(32'h00500093, TO, 0, 1'b0);
    model_trap(5);
    run_trace(1000);
    do_reset();

    cur_tag = "ready_last_cycle";
    model_idle();
    model_instr(32'h00500093, TO - 1, 0, 1'b0);
    model_instr(32'h0040A103, 0, TO - 1, 1'b0);
    run_trace(1000);

    cur_tag = "mem_timeout";
    model_instr(32'h0020A423, 0, TO, 1'b0);
    model_trap(4);
    run_trace(1000);
    do_reset();

    cur_tag = "mid_mem_reset";
    model_idle();
    model_instr(32'h0020A423, 0, 5, 1'b0);
    run_trace(5);
    dmem_ready = 1'b0;
    #1;
    n_tests++;
    assert (dmem_req === 1'b1) else begin
      n_fail++;
      $error("FAIL mid_mem_req: observed %b expected %b", dmem_req, 1'b1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    assert (obs === 16'h0000) else begin
      n_fail++;
      $error("FAIL mid_mem_reset_drop: observed %h expected %h", obs, 16'h0000);
    end
    do_reset();

    cur_tag = "restart";
    model_idle();
    model_instr(32'h00500093, 0, 0, 1'b0);
    model_instr(32'h0040A103, 0, 0, 1'b0);
    run_trace(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
